io_device: RTL and testbench

- Peripheral model that sits at the far end of the processor's input and output device handshakes.
- Input side: offers queued bytes to the processor on input_bus using in_dev_hs / in_dev_ack.
- Output side: accepts bytes from the processor's output_bus using out_dev_hs / out_valid / out_dev_ack.
- A host/testbench side loads the TX queue and drains the RX queue, so programs doing I/O can run in simulation and on the board.

---
 rtl/io_device.sv | 208 ++++++++++++++++++++
 tb/tb_io_device.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_device.sv
// io_device: peripheral model at the far end of the processor's I/O handshakes.
//
// A host side fills a TX FIFO that is offered to the processor one byte at a
// time over a four-phase handshake (in_dev_hs / in_dev_ack). Bytes the
// processor writes (output_bus / out_valid) are captured into an RX FIFO over
// a second, independent four-phase handshake (out_dev_hs / out_dev_ack). The
// host drains the RX FIFO.
//
// Ports
//   g_clk, g_clr        clock; asynchronous active-high clear
//   host_wr/host_wdata  push a byte into TX; host_full flags TX full
//   host_rd/host_rdata  pop RX head; host_rdata is 0 while host_empty
//   tx_count, rx_count  FIFO occupancies
//   in_dev_hs/input_bus registered offer to the processor; in_dev_ack back
//   out_dev_hs          ready to accept; output_bus/out_valid from processor
//   out_dev_ack         captured-byte acknowledge
module io_device #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic             host_wr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_full,
  input  logic             host_rd,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_empty,
  output logic [CW-1:0]    tx_count,
  output logic [CW-1:0]    rx_count,
  output logic             in_dev_hs,
  output logic [WIDTH-1:0] input_bus,
  input  logic             in_dev_ack,
  output logic             out_dev_hs,
  input  logic [WIDTH-1:0] output_bus,
  input  logic             out_valid,
  output logic             out_dev_ack
);

  localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [1:0] {InIdle, InOffer, InRelease} in_state_e;
  typedef enum logic [1:0] {OutIdle, OutReady, OutAck} out_state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] tx_mem_q [DEPTH];
  logic [WIDTH-1:0] rx_mem_q [DEPTH];
  logic [PW-1:0]    tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]    tx_cnt_q, rx_cnt_q;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  in_state_e        in_state_q, in_state_d;
  logic             in_hs_q, in_hs_d;
  logic [WIDTH-1:0] in_bus_q, in_bus_d;

  out_state_e       out_state_q, out_state_d;
  logic             out_hs_q, out_hs_d;
  logic             out_ack_q, out_ack_d;

  // A pop in the same cycle frees the slot, so a push while full is accepted.
  assign tx_pop  = (in_state_q == InOffer) && in_dev_ack && (tx_cnt_q != '0);
  assign tx_push = host_wr && ((tx_cnt_q != FullCount) || tx_pop);
  assign rx_pop  = host_rd && (rx_cnt_q != '0);
  assign rx_push = (out_state_q == OutReady) && out_valid &&
                   ((rx_cnt_q != FullCount) || rx_pop);

  // Storage carries no reset: contents are only observable through the
  // pointers and counts, which are cleared.
  always_ff @(posedge g_clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= host_wdata;
    if (rx_push) rx_mem_q[rx_wptr_q] <= output_bus;
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Input handshake: offer TX head to the processor
  // ---------------------------------------------------------------------------
  always_comb begin
    in_state_d = in_state_q;
    in_hs_d    = in_hs_q;
    in_bus_d   = in_bus_q;
    case (in_state_q)
      InIdle: begin
        // A lingering ack from the previous transfer must not start a new one.
        if ((tx_cnt_q != '0) && !in_dev_ack) begin
          in_state_d = InOffer;
          in_hs_d    = 1'b1;
          in_bus_d   = tx_mem_q[tx_rptr_q];
        end
      end
      InOffer: begin
        if (in_dev_ack) begin
          in_state_d = InRelease;
          in_hs_d    = 1'b0;
        end
      end
      InRelease: begin
        if (!in_dev_ack) in_state_d = InIdle;
      end
      default: begin
        in_state_d = InIdle;
        in_hs_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      in_state_q <= InIdle;
      in_hs_q    <= 1'b0;
      in_bus_q   <= '0;
    end else begin
      in_state_q <= in_state_d;
      in_hs_q    <= in_hs_d;
      in_bus_q   <= in_bus_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake: capture processor bytes into RX
  // ---------------------------------------------------------------------------
  always_comb begin
    out_state_d = out_state_q;
    out_hs_d    = out_hs_q;
    out_ack_d   = out_ack_q;
    case (out_state_q)
      OutIdle: begin
        if (rx_cnt_q < FullCount) begin
          out_state_d = OutReady;
          out_hs_d    = 1'b1;
        end
      end
      OutReady: begin
        if (out_valid) begin
          out_state_d = OutAck;
          out_hs_d    = 1'b0;
          out_ack_d   = 1'b1;
        end
      end
      OutAck: begin
        if (!out_valid) begin
          out_state_d = OutIdle;
          out_ack_d   = 1'b0;
        end
      end
      default: begin
        out_state_d = OutIdle;
        out_hs_d    = 1'b0;
        out_ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      out_state_q <= OutIdle;
      out_hs_q    <= 1'b0;
      out_ack_q   <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      out_hs_q    <= out_hs_d;
      out_ack_q   <= out_ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign host_full   = (tx_cnt_q == FullCount);
  assign host_empty  = (rx_cnt_q == '0);
  assign host_rdata  = host_empty ? '0 : rx_mem_q[rx_rptr_q];
  assign tx_count    = tx_cnt_q;
  assign rx_count    = rx_cnt_q;
  assign in_dev_hs   = in_hs_q;
  assign input_bus   = in_bus_q;
  assign out_dev_hs  = out_hs_q;
  assign out_dev_ack = out_ack_q;

endmodule

// File: tb/tb_io_device.sv
module tb_io_device;

  logic       g_clk = 1'b0;
  logic       g_clr = 1'b1;
  logic       host_wr = 1'b0;
  logic [7:0] host_wdata = '0;
  logic       host_full;
  logic       host_rd = 1'b0;
  logic [7:0] host_rdata;
  logic       host_empty;
  logic [2:0] tx_count, rx_count;
  logic       in_dev_hs;
  logic [7:0] input_bus;
  logic       in_dev_ack = 1'b0;
  logic       out_dev_hs;
  logic [7:0] output_bus = '0;
  logic       out_valid = 1'b0;
  logic       out_dev_ack;

  io_device #(.WIDTH(8), .DEPTH(4), .CW(3)) dut (
    .g_clk      (g_clk),
    .g_clr      (g_clr),
    .host_wr    (host_wr),
    .host_wdata (host_wdata),
    .host_full  (host_full),
    .host_rd    (host_rd),
    .host_rdata (host_rdata),
    .host_empty (host_empty),
    .tx_count   (tx_count),
    .rx_count   (rx_count),
    .in_dev_hs  (in_dev_hs),
    .input_bus  (input_bus),
    .in_dev_ack (in_dev_ack),
    .out_dev_hs (out_dev_hs),
    .output_bus (output_bus),
    .out_valid  (out_valid),
    .out_dev_ack(out_dev_ack)
  );

  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference streams: what the processor should receive, and what the host
  // should read back, in order.
  logic [7:0] exp_in[$];
  logic [7:0] got_in[$];
  logic [7:0] exp_rx[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    host_wr    = 1'b1;
    host_wdata = b;
    step();
    host_wr    = 1'b0;
  endtask

  task automatic host_pop(input string tag, input logic [7:0] b);
    check_eq(tag, 32'(host_rdata), 32'(b));
    host_rd = 1'b1;
    step();
    host_rd = 1'b0;
  endtask

  // Processor side of the input handshake: take n offers.
  task automatic proc_take(input int n, input int dly, input int hold, input bit rnd);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      int d;
      int h;
      logic [7:0] b;
      while (!in_dev_hs && t < 300) begin
        step();
        t++;
      end
      check_eq("in_offer_wait", 32'(in_dev_hs), 32'd1);
      if (!in_dev_hs) return;
      b = input_bus;
      d = rnd ? int'($urandom_range(0, 4)) : dly;
      h = rnd ? int'($urandom_range(1, 3)) : hold;
      for (int i = 0; i < d; i++) begin
        step();
        check_eq("in_bus_stable", 32'(input_bus), 32'(b));
        check_eq("in_hs_held", 32'(in_dev_hs), 32'd1);
      end
      in_dev_ack = 1'b1;
      step();
      check_eq("in_hs_drop", 32'(in_dev_hs), 32'd0);
      for (int i = 1; i < h; i++) step();
      in_dev_ack = 1'b0;
      got_in.push_back(b);
    end
  endtask

  // Processor side of the output handshake: deliver one byte.
  task automatic dev_give(input logic [7:0] b, input int hold);
    int t = 0;
    while (!out_dev_hs && t < 300) begin
      step();
      t++;
    end
    check_eq("out_ready_wait", 32'(out_dev_hs), 32'd1);
    if (!out_dev_hs) return;
    output_bus = b;
    out_valid  = 1'b1;
    step();
    check_eq("out_ack_rise", 32'(out_dev_ack), 32'd1);
    check_eq("out_hs_fall", 32'(out_dev_hs), 32'd0);
    for (int i = 1; i < hold; i++) begin
      step();
      check_eq("out_ack_hold", 32'(out_dev_ack), 32'd1);
    end
    out_valid = 1'b0;
    step();
    check_eq("out_ack_fall", 32'(out_dev_ack), 32'd0);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_len"}, 32'(got_in.size()), 32'(exp_in.size()));
    for (int i = 0; i < exp_in.size() && i < got_in.size(); i++)
      check_eq(tag, 32'(got_in[i]), 32'(exp_in[i]));
    got_in.delete();
    exp_in.delete();
  endtask

  task automatic rand_writer(input int n);
    int sent = 0;
    int t = 0;
    while (sent < n && t < 6000) begin
      if (!host_full && $urandom_range(0, 1) == 1) begin
        logic [7:0] b;
        b = 8'($urandom);
        host_wr    = 1'b1;
        host_wdata = b;
        exp_in.push_back(b);
        sent++;
      end else begin
        host_wr = 1'b0;
      end
      step();
      t++;
    end
    host_wr = 1'b0;
  endtask

  task automatic rand_giver(input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_rx.push_back(b);
      dev_give(b, int'($urandom_range(1, 3)));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
    end
  endtask

  task automatic rand_reader(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 6000) begin
      if (!host_empty && $urandom_range(0, 2) == 0) begin
        if (exp_rx.size() == 0) begin
          check_eq("rx_unexpected", 32'(host_empty), 32'd1);
          host_rd = 1'b0;
        end else begin
          check_eq("rx_rand_data", 32'(host_rdata), 32'(exp_rx.pop_front()));
          host_rd = 1'b1;
          got++;
        end
      end else begin
        host_rd = 1'b0;
      end
      step();
      t++;
    end
    host_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    step();
    check_eq("rst_in_hs", 32'(in_dev_hs), 32'd0);
    check_eq("rst_input_bus", 32'(input_bus), 32'd0);
    check_eq("rst_out_hs", 32'(out_dev_hs), 32'd0);
    check_eq("rst_out_ack", 32'(out_dev_ack), 32'd0);
    check_eq("rst_full", 32'(host_full), 32'd0);
    check_eq("rst_empty", 32'(host_empty), 32'd1);
    check_eq("rst_rdata", 32'(host_rdata), 32'd0);
    check_eq("rst_tx_count", 32'(tx_count), 32'd0);
    check_eq("rst_rx_count", 32'(rx_count), 32'd0);
    g_clr = 1'b0;
    step();
    check_eq("ready_after_rst", 32'(out_dev_hs), 32'd1);

    // Reset mid-offer
    host_push(8'hA5);
    check_eq("offer_not_yet", 32'(in_dev_hs), 32'd0);
    step();
    check_eq("offer_hs", 32'(in_dev_hs), 32'd1);
    check_eq("offer_bus", 32'(input_bus), 32'hA5);
    #2 g_clr = 1'b1;
    #1;
    check_eq("clr_in_hs", 32'(in_dev_hs), 32'd0);
    check_eq("clr_input_bus", 32'(input_bus), 32'd0);
    check_eq("clr_tx_count", 32'(tx_count), 32'd0);
    g_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("no_offer_after_clr", 32'(in_dev_hs), 32'd0);
    end

    // Input stream, acked 3 cycles late, ack held 2 cycles
    exp_in = '{8'h11, 8'h22, 8'h33};
    fork
      begin
        host_push(8'h11);
        host_push(8'h22);
        host_push(8'h33);
      end
      proc_take(3, 3, 2, 1'b0);
    join
    step();
    check_stream("in_stream");
    check_eq("in_stream_tx_count", 32'(tx_count), 32'd0);

    // TX full: 0x05 dropped
    for (int i = 1; i <= 5; i++) begin
      host_push(8'(i));
      if (i == 3) check_eq("tx_not_full3", 32'(host_full), 32'd0);
      if (i >= 4) check_eq("tx_full", 32'(host_full), 32'd1);
    end
    check_eq("tx_full_count", 32'(tx_count), 32'd4);
    exp_in = '{8'h01, 8'h02, 8'h03, 8'h04};
    proc_take(4, 1, 1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check_eq("tx_drop_no_offer", 32'(in_dev_hs), 32'd0);
    check_eq("tx_drop_count", 32'(tx_count), 32'd0);
    check_stream("tx_full_seq");

    // Output capture
    check_eq("cap_ready", 32'(out_dev_hs), 32'd1);
    output_bus = 8'h5A;
    out_valid  = 1'b1;
    step();
    check_eq("cap_ack", 32'(out_dev_ack), 32'd1);
    check_eq("cap_hs", 32'(out_dev_hs), 32'd0);
    check_eq("cap_rdata", 32'(host_rdata), 32'h5A);
    check_eq("cap_rx_count", 32'(rx_count), 32'd1);
    check_eq("cap_not_empty", 32'(host_empty), 32'd0);
    step();
    check_eq("cap_ack_held", 32'(out_dev_ack), 32'd1);
    out_valid = 1'b0;
    step();
    check_eq("cap_ack_drop", 32'(out_dev_ack), 32'd0);
    host_pop("cap_pop", 8'h5A);
    check_eq("cap_drained", 32'(host_empty), 32'd1);
    check_eq("cap_drained_rdata", 32'(host_rdata), 32'd0);

    // RX full backpressure
    for (int i = 0; i < 4; i++) dev_give(8'hC0 + 8'(i), 1);
    step();
    step();
    check_eq("rx_full_count", 32'(rx_count), 32'd4);
    check_eq("rx_full_hs", 32'(out_dev_hs), 32'd0);
    output_bus = 8'hFF;
    out_valid  = 1'b1;
    step();
    step();
    out_valid  = 1'b0;
    step();
    check_eq("rx_full_no_cap", 32'(rx_count), 32'd4);
    check_eq("rx_full_no_ack", 32'(out_dev_ack), 32'd0);
    host_pop("rx_full_head", 8'hC0);
    begin
      int t = 0;
      while (!out_dev_hs && t < 2) begin
        step();
        t++;
      end
    end
    check_eq("rx_hs_reassert", 32'(out_dev_hs), 32'd1);
    dev_give(8'hFF, 1);
    host_pop("rx_tail1", 8'hC1);
    host_pop("rx_tail2", 8'hC2);
    host_pop("rx_tail3", 8'hC3);
    host_pop("rx_tail4", 8'hFF);
    check_eq("rx_tail_empty", 32'(host_empty), 32'd1);

    // Concurrent: same-cycle push and pop on both FIFOs at count 2
    dev_give(8'h71, 1);
    dev_give(8'h72, 1);
    host_push(8'h61);
    host_push(8'h62);
    check_eq("cc_tx_count", 32'(tx_count), 32'd2);
    check_eq("cc_in_hs", 32'(in_dev_hs), 32'd1);
    check_eq("cc_in_bus", 32'(input_bus), 32'h61);
    check_eq("cc_out_hs", 32'(out_dev_hs), 32'd1);
    check_eq("cc_rx_head", 32'(host_rdata), 32'h71);
    in_dev_ack = 1'b1;
    host_wr    = 1'b1;
    host_wdata = 8'h63;
    out_valid  = 1'b1;
    output_bus = 8'h73;
    host_rd    = 1'b1;
    step();
    in_dev_ack = 1'b0;
    host_wr    = 1'b0;
    out_valid  = 1'b0;
    host_rd    = 1'b0;
    check_eq("cc_tx_same", 32'(tx_count), 32'd2);
    check_eq("cc_rx_same", 32'(rx_count), 32'd2);
    check_eq("cc_rx_next", 32'(host_rdata), 32'h72);
    check_eq("cc_in_released", 32'(in_dev_hs), 32'd0);
    check_eq("cc_out_ack", 32'(out_dev_ack), 32'd1);
    exp_in = '{8'h62, 8'h63};
    proc_take(2, 1, 1, 1'b0);
    check_stream("cc_in_seq");
    host_pop("cc_rx1", 8'h72);
    host_pop("cc_rx2", 8'h73);

    // Randomized concurrent traffic against queue model
    fork
      rand_writer(40);
      proc_take(40, 0, 0, 1'b1);
      rand_giver(40);
      rand_reader(40);
    join
    for (int i = 0; i < 4; i++) step();
    check_stream("rand_in");
    check_eq("rand_rx_left", 32'(exp_rx.size()), 32'd0);
    check_eq("rand_tx_count", 32'(tx_count), 32'd0);
    check_eq("rand_rx_count", 32'(rx_count), 32'd0);
    check_eq("rand_empty", 32'(host_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
